// File: rtl/lse_pkg.sv
// Constants and types shared across the LSE datapath.
package lse_pkg;
  localparam int LSE_INT_BITS  = 12;
  localparam int LSE_FRAC_BITS = 3;

  typedef logic [15:0] lse_word_t;

  // Sign clear with the most negative magnitude encodes log(0).
  localparam lse_word_t NEG_INF_16 = 16'h4000;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_SAT  = 1;
endpackage

// File: rtl/lse_exp2_shift.sv
// Bidirectional barrel shifter for the exp2 stage: unsigned m * 2^s with overflow flag.
// LSE_LOG2LIN_ROUND_EN: right shifts round half-up instead of truncating.
module lse_exp2_shift #(
  parameter int MW        = 4,
  parameter int SW        = 20,
  parameter int OUT_WIDTH = 32
) (
  input  logic [MW-1:0]        m,
  input  logic signed [SW-1:0] s,
  output logic [OUT_WIDTH-1:0] res,
  output logic                 ovf
);
  localparam int LW = $clog2(OUT_WIDTH);
  localparam int RW = $clog2(MW + 3);
  // Largest left shift that keeps m below the output sign bit.
  localparam logic signed [SW-1:0] S_MAX = SW'(OUT_WIDTH - 1 - MW);
`ifdef LSE_LOG2LIN_ROUND_EN
  localparam logic signed [SW-1:0] UF = SW'(MW + 1);
`else
  localparam logic signed [SW-1:0] UF = SW'(MW);
`endif
  localparam logic [MW:0] ONE = 1;

  logic [OUT_WIDTH-1:0] m_ext;
  logic [MW:0]          m_rnd;
  logic [LW-1:0]        lsh;
  logic [RW-1:0]        rsh;
  logic signed [SW-1:0] neg_s;

  always_comb begin
    m_ext = {{(OUT_WIDTH-MW){1'b0}}, m};
    neg_s = -s;
    res   = '0;
    ovf   = 1'b0;
    lsh   = '0;
    rsh   = '0;
    m_rnd = '0;
    if (s > S_MAX) begin
      ovf = 1'b1;
    end else if (!s[SW-1]) begin
      lsh = LW'(s);
      res = m_ext << lsh;
    end else if (neg_s <= UF) begin
      rsh = RW'(neg_s);
`ifdef LSE_LOG2LIN_ROUND_EN
      m_rnd = {1'b0, m} + (ONE << (rsh - RW'(1)));
`else
      m_rnd = {1'b0, m};
`endif
      res = OUT_WIDTH'(m_rnd >> rsh);
    end
  end
endmodule

// File: rtl/lse_log2lin.sv
// Three-stage log-domain to signed linear fixed-point converter (Mitchell 2^f ~ 1+f).
// LSE_LOG2LIN_ROUND_EN selects round-half-up right shifts; latency and ports are unchanged.
module lse_log2lin
  import lse_pkg::*;
#(
  parameter int INT_BITS      = LSE_INT_BITS,
  parameter int FRAC_BITS     = LSE_FRAC_BITS,
  parameter int WIDTH         = INT_BITS + FRAC_BITS + 1,
  parameter int OUT_WIDTH     = 32,
  parameter int OUT_FRAC_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [1:0]           out_flags,
  input  logic                 sat_clr,
  output logic [15:0]          sat_count
);
  localparam int STAGES = 3;
  localparam int MW     = FRAC_BITS + 1;
  localparam int EW     = WIDTH - 1 - FRAC_BITS;
  localparam int SW     = EW + 8;
  localparam logic signed [SW-1:0]  S_OFS     = SW'(OUT_FRAC_BITS - FRAC_BITS);
  localparam logic [WIDTH-1:0]      NEG_INF_W = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic [OUT_WIDTH-1:0]  SAT_MAX   = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  // Stage valids; bit 0 is the incoming word so stage k loads from k-1.
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] adv, ld;
  logic            adv1, adv2, adv3;

  assign vld_pipe  = {vld_pipe_q, in_valid};
  assign adv3      = !vld_pipe[3] || out_ready;
  assign adv2      = !vld_pipe[2] || adv3;
  assign adv1      = !vld_pipe[1] || adv2;
  assign adv       = {adv3, adv2, adv1};
  assign ld        = adv & vld_pipe[STAGES-1:0];
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[3];

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    for (int k = 1; k <= STAGES; k++)
      if (adv[k]) vld_pipe_d[k] = vld_pipe[k-1];
  end

  // S1: decode and log(0) detection
  logic signed [EW-1:0] e0;
  logic                 sign1_q, sign1_d, ninf1_q, ninf1_d;
  logic [MW-1:0]        m1_q, m1_d;
  logic signed [SW-1:0] s1_q, s1_d;

  always_comb begin
    e0      = in_data[WIDTH-2:FRAC_BITS];
    sign1_d = sign1_q;
    ninf1_d = ninf1_q;
    m1_d    = m1_q;
    s1_d    = s1_q;
    if (ld[1]) begin
      sign1_d = in_data[WIDTH-1];
      ninf1_d = (in_data == NEG_INF_W);
      m1_d    = {1'b1, in_data[FRAC_BITS-1:0]};
      s1_d    = SW'(e0) + S_OFS;
    end
  end

  // S2: barrel shift
  logic [OUT_WIDTH-1:0] sh_res, res2_q, res2_d;
  logic                 sh_ovf, ovf2_q, ovf2_d, sign2_q, sign2_d, ninf2_q, ninf2_d;

  lse_exp2_shift #(.MW(MW), .SW(SW), .OUT_WIDTH(OUT_WIDTH)) u_shift (
    .m   (m1_q),
    .s   (s1_q),
    .res (sh_res),
    .ovf (sh_ovf)
  );

  always_comb begin
    sign2_d = sign2_q;
    ninf2_d = ninf2_q;
    res2_d  = res2_q;
    ovf2_d  = ovf2_q;
    if (ld[2]) begin
      sign2_d = sign1_q;
      ninf2_d = ninf1_q;
      res2_d  = sh_res;
      ovf2_d  = sh_ovf;
    end
  end

  // S3: saturate, apply sign, flags; held while the consumer stalls
  logic [OUT_WIDTH-1:0] mag3, out_data_q, out_data_d;
  logic [1:0]           out_flags_q, out_flags_d;
  logic [15:0]          sat_count_q, sat_count_d;

  always_comb begin
    mag3        = ninf2_q ? '0 : (ovf2_q ? SAT_MAX : res2_q);
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    if (ld[3]) begin
      out_data_d             = sign2_q ? -mag3 : mag3;
      out_flags_d[FLAG_ZERO] = (mag3 == '0);
      out_flags_d[FLAG_SAT]  = ovf2_q && !ninf2_q;
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr)
      sat_count_d = '0;
    else if (out_valid && out_ready && out_flags_q[FLAG_SAT] && sat_count_q != 16'hFFFF)
      sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      sign1_q     <= 1'b0;
      ninf1_q     <= 1'b0;
      m1_q        <= '0;
      s1_q        <= '0;
      sign2_q     <= 1'b0;
      ninf2_q     <= 1'b0;
      res2_q      <= '0;
      ovf2_q      <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      sat_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      sign1_q     <= sign1_d;
      ninf1_q     <= ninf1_d;
      m1_q        <= m1_d;
      s1_q        <= s1_d;
      sign2_q     <= sign2_d;
      ninf2_q     <= ninf2_d;
      res2_q      <= res2_d;
      ovf2_q      <= ovf2_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign sat_count = sat_count_q;
endmodule

// File: tb/tb_lse_log2lin.sv
// Bench for lse_log2lin: directed vectors with latency, saturation counter, and a
// randomly stalled stream with a mid-stream reset checked against a value-level model.
module tb_lse_log2lin;
  import lse_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, sat_clr = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] in_data = '0;
  logic [31:0] out_data;
  logic [1:0]  out_flags;
  logic [15:0] sat_count;
  int checks = 0, failures = 0;

`ifdef LSE_LOG2LIN_ROUND_EN
  localparam logic [31:0] TINY_D = 32'h0000_0001;
  localparam logic [1:0]  TINY_F = 2'b00;
`else
  localparam logic [31:0] TINY_D = 32'h0000_0000;
  localparam logic [1:0]  TINY_F = 2'b01;
`endif

  lse_log2lin dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Value-level model: sign * (1 + f/8) * 2^e scaled by 2^16, returns {flags, data}.
  function automatic logic [33:0] model(input logic [15:0] w);
    longint mag, f, e, s, m, u, d;
    logic [14:0] mraw;
    logic [31:0] y;
    bit sat;
    if (w == NEG_INF_16) return {2'b01, 32'd0};
    mraw = w[14:0];
    mag  = longint'($signed(mraw));
    f    = ((mag % 8) + 8) % 8;
    e    = (mag - f) / 8;
    m    = 8 + f;
    s    = e + 16 - 3;
    sat  = 0;
    if (s > 40) begin
      u = 64'h7FFF_FFFF; sat = 1;
    end else if (s >= 0) begin
      u = m * (longint'(1) << s);
      if (u > 64'h7FFF_FFFF) begin u = 64'h7FFF_FFFF; sat = 1; end
    end else if (-s > 40) begin
      u = 0;
    end else begin
      d = longint'(1) << (-s);
`ifdef LSE_LOG2LIN_ROUND_EN
      u = (m + d / 2) / d;
`else
      u = m / d;
`endif
    end
    y = w[15] ? 32'(-u) : 32'(u);
    return {sat, (u == 0), y};
  endfunction

  function automatic logic [15:0] gen_word();
    int k = int'($urandom_range(0, 7));
    int mg;
    logic [15:0] w;
    if (k == 0) w = 16'($urandom);
    else if (k == 1) w = NEG_INF_16;
    else begin
      mg = int'($urandom_range(0, 330)) - 190;
      w  = {1'($urandom_range(0, 1)), 15'(mg)};
    end
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_flags !== 2'b00) begin failures++; $display("FAIL reset_out_flags: got %b expected 00", out_flags); end
    checks++; if (sat_count !== 16'h0) begin failures++; $display("FAIL reset_sat_count: got %h expected 0", sat_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] ws [8] = '{16'h0000, 16'h0004, 16'h0008, 16'h8000, 16'h4000, 16'h0078, 16'h8078, 16'h7F78};
    logic [31:0] ed [8] = '{32'h0001_0000, 32'h0001_8000, 32'h0002_0000, 32'hFFFF_0000,
                            32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0001, TINY_D};
    logic [1:0]  ef [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, TINY_F};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = ws[i]; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 1'(c == 2)) begin
          failures++; $display("FAIL latency[%h] cycle %0d: got out_valid=%b expected %b", ws[i], c + 1, out_valid, c == 2);
        end
      end
      checks++;
      if (out_data !== ed[i]) begin failures++; $display("FAIL data[%h]: got %h expected %h", ws[i], out_data, ed[i]); end
      checks++;
      if (out_flags !== ef[i]) begin failures++; $display("FAIL flags[%h]: got %b expected %b", ws[i], out_flags, ef[i]); end
    end
  endtask

  task automatic test_sat_count();
    @(posedge clk); #1;
    checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL sat_count_two: got %0d expected 2", sat_count); end
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL sat_clr_idle: got %0d expected 0", sat_count); end
    // Saturated word parked at the output, then clear and accept in the same cycle.
    in_valid = 1'b1; in_data = 16'h0078; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h7FFF_FFFF || out_flags !== 2'b10) begin
      failures++; $display("FAIL sat_stall_hold: got v=%b d=%h f=%b expected v=1 d=7fffffff f=10", out_valid, out_data, out_flags);
    end
    checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL sat_count_stalled: got %0d expected 0", sat_count); end
    sat_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL sat_clr_priority: got %0d expected 0", sat_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain: got out_valid=%b expected 0", out_valid); end
    in_valid = 1'b1; in_data = 16'h8078;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sat_count !== 16'd1) begin failures++; $display("FAIL sat_count_resume: got %0d expected 1", sat_count); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_q[$];
    logic [33:0] exp_w;
    logic [31:0] held_d;
    logic [1:0]  held_f;
    int gen = 0, cyc = 0;
    bit acc = 0, stall = 0, did_rst = 0;
    held_d = '0; held_f = '0;
    in_valid = 1'b0;
    while ((gen < 24 || in_valid || exp_q.size() != 0) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) in_valid = 1'b0;
      acc = 0;
      if (!rst_n) rst_n = 1'b1;
      else if (!did_rst && gen == 12) begin
        rst_n = 1'b0; did_rst = 1; in_valid = 1'b0; stall = 0;
        exp_q.delete();
      end
      if (rst_n) begin
        if (!in_valid && gen < 24 && $urandom_range(0, 3) != 0) begin
          in_data = gen_word(); in_valid = 1'b1; gen++;
        end
        out_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      if (!rst_n) begin
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
          failures++; $display("FAIL stream_in_reset: got v=%b d=%h expected v=0 d=0", out_valid, out_data);
        end
      end else begin
        if (stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== held_d || out_flags !== held_f) begin
            failures++; $display("FAIL stream_stall_hold: got v=%b d=%h f=%b expected v=1 d=%h f=%b",
                                 out_valid, out_data, out_flags, held_d, held_f);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL stream_extra: got d=%h f=%b expected no output", out_data, out_flags);
          end else begin
            exp_w = exp_q.pop_front();
            if ({out_flags, out_data} !== exp_w) begin
              failures++; $display("FAIL stream_data: got d=%h f=%b expected d=%h f=%b",
                                   out_data, out_flags, exp_w[31:0], exp_w[33:32]);
            end
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(in_data));
          acc = 1;
        end
        stall  = out_valid && !out_ready;
        held_d = out_data;
        held_f = out_flags;
      end
    end
    checks++;
    if (exp_q.size() != 0 || in_valid) begin
      failures++; $display("FAIL stream_drain: got %0d words outstanding expected 0", exp_q.size());
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sat_count();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
